// File: rtl/frv_pipeline_memory.sv
// Memory pipeline stage: forwards non-LSU results and runs one load/store
// transaction at a time on the dmem request/response bus.
module frv_pipeline_memory #(
    parameter int unsigned XL        = 31,
    parameter int unsigned P_FU_LSU  = 2,
    parameter int unsigned LSU_LOAD  = 4,
    parameter int unsigned LSU_STORE = 3
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        flush,
    input  logic [4:0]  s3_rd,
    input  logic [XL:0] s3_opr_a,
    input  logic [XL:0] s3_opr_b,
    input  logic [4:0]  s3_uop,
    input  logic [4:0]  s3_fu,
    input  logic        s3_trap,
    input  logic        s3_valid,
    output logic        s3_busy,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic        dmem_wen,
    output logic [3:0]  dmem_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_recv,
    input  logic        dmem_error,
    input  logic [31:0] dmem_rdata,
    output logic [4:0]  s4_rd,
    output logic [XL:0] s4_wdata,
    output logic [4:0]  s4_fu,
    output logic        s4_trap,
    output logic [5:0]  s4_cause,
    output logic        s4_valid,
    input  logic        s4_busy
);

    localparam logic [5:0] CAUSE_LD_MISALIGN = 6'd4;
    localparam logic [5:0] CAUSE_LD_FAULT    = 6'd5;
    localparam logic [5:0] CAUSE_ST_MISALIGN = 6'd6;
    localparam logic [5:0] CAUSE_ST_FAULT    = 6'd7;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DRAIN} state_t;

    state_t      state_q, state_nxt;
    logic        kill_q, kill_nxt;
    logic        capture, s4_ld_pass, s4_ld_rsp;

    logic [1:0]  s3_width;
    logic        s3_lsu, s3_store, s3_aligned, s3_direct, xfer;
    logic [3:0]  strb_base, strb_c;
    logic [31:0] wdata_c, rshift_c, ldata_c;

    logic [XL:0] lsu_addr_q;
    logic        lsu_store_q, lsu_zext_q;
    logic [1:0]  lsu_width_q;
    logic [4:0]  lsu_rd_q, lsu_fu_q;

    assign s3_busy  = (state_q != IDLE) || (s4_valid && s4_busy);
    assign s3_width = s3_uop[2:1];
    assign s3_lsu   = s3_fu[P_FU_LSU];
    assign s3_store = s3_uop[LSU_STORE] & ~s3_uop[LSU_LOAD];
    assign s3_direct = !s3_lsu || s3_trap || !s3_aligned;
    assign xfer     = s3_valid && !s3_busy && !flush;

    // Request payload derived from the incoming micro-op
    always_comb begin
        s3_aligned = 1'b0;
        strb_base  = 4'b1111;
        wdata_c    = s3_opr_b[31:0];
        case (s3_width)
            2'b00: begin
                s3_aligned = 1'b1;
                strb_base  = 4'b0001;
                wdata_c    = {4{s3_opr_b[7:0]}};
            end
            2'b01: begin
                s3_aligned = ~s3_opr_a[0];
                strb_base  = 4'b0011;
                wdata_c    = {2{s3_opr_b[15:0]}};
            end
            2'b10: s3_aligned = (s3_opr_a[1:0] == 2'b00);
            default: s3_aligned = 1'b0;
        endcase
        strb_c = s3_store ? 4'(strb_base << s3_opr_a[1:0]) : 4'b0000;
    end

    // Load data alignment and extension
    always_comb begin
        rshift_c = dmem_rdata >> {lsu_addr_q[1:0], 3'b000};
        case (lsu_width_q)
            2'b00:   ldata_c = {{24{~lsu_zext_q & rshift_c[7]}}, rshift_c[7:0]};
            2'b01:   ldata_c = {{16{~lsu_zext_q & rshift_c[15]}}, rshift_c[15:0]};
            default: ldata_c = rshift_c;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            state_q <= IDLE;
            kill_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            kill_q  <= kill_nxt;
        end
    end

    // A flush during REQ is remembered so the granted access is drained, not returned
    always_comb begin
        state_nxt  = state_q;
        kill_nxt   = kill_q;
        capture    = 1'b0;
        s4_ld_pass = 1'b0;
        s4_ld_rsp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    if (s3_direct) begin
                        s4_ld_pass = 1'b1;
                    end else begin
                        capture   = 1'b1;
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    state_nxt = (flush || kill_q) ? DRAIN : RSP;
                    kill_nxt  = 1'b0;
                end else if (flush) begin
                    kill_nxt = 1'b1;
                end
            end
            RSP: begin
                if (dmem_recv) begin
                    state_nxt = IDLE;
                    s4_ld_rsp = !flush;
                end else if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem_recv) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge g_clk or posedge g_reset) begin
        if (g_reset) begin
            dmem_req    <= 1'b0;
            dmem_wen    <= 1'b0;
            dmem_strb   <= 4'b0000;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            lsu_addr_q  <= '0;
            lsu_store_q <= 1'b0;
            lsu_zext_q  <= 1'b0;
            lsu_width_q <= 2'b00;
            lsu_rd_q    <= 5'd0;
            lsu_fu_q    <= 5'd0;
            s4_valid    <= 1'b0;
            s4_rd       <= 5'd0;
            s4_wdata    <= '0;
            s4_fu       <= 5'd0;
            s4_trap     <= 1'b0;
            s4_cause    <= 6'd0;
        end else begin
            dmem_req <= (state_nxt == REQ);
            if (capture) begin
                dmem_wen    <= s3_store;
                dmem_strb   <= strb_c;
                dmem_addr   <= {s3_opr_a[31:2], 2'b00};
                dmem_wdata  <= wdata_c;
                lsu_addr_q  <= s3_opr_a;
                lsu_store_q <= s3_store;
                lsu_zext_q  <= s3_uop[0];
                lsu_width_q <= s3_width;
                lsu_rd_q    <= s3_rd;
                lsu_fu_q    <= s3_fu;
            end
            if (flush) begin
                s4_valid <= 1'b0;
            end else if (s4_ld_pass) begin
                // A direct LSU op without an upstream trap can only be misaligned
                s4_valid <= 1'b1;
                s4_rd    <= s3_rd;
                s4_fu    <= s3_fu;
                s4_wdata <= s3_opr_a;
                s4_trap  <= s3_trap || s3_lsu;
                if (s3_trap) begin
                    s4_cause <= s3_opr_b[5:0];
                end else if (s3_lsu) begin
                    s4_cause <= s3_store ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
                end else begin
                    s4_cause <= 6'd0;
                end
            end else if (s4_ld_rsp) begin
                s4_valid <= 1'b1;
                s4_rd    <= lsu_rd_q;
                s4_fu    <= lsu_fu_q;
                if (dmem_error) begin
                    s4_trap  <= 1'b1;
                    s4_cause <= lsu_store_q ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
                    s4_wdata <= lsu_addr_q;
                end else begin
                    s4_trap  <= 1'b0;
                    s4_cause <= 6'd0;
                    s4_wdata <= lsu_store_q ? '0 : ldata_c;
                end
            end else if (s4_valid && !s4_busy) begin
                s4_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_frv_pipeline_memory.sv
// Randomised bench for frv_pipeline_memory against a transaction-level model,
// plus directed scenarios with literal expectations.
module tb_frv_pipeline_memory;

    localparam int unsigned XL       = 31;
    localparam int unsigned P_FU_LSU = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        flush;
    logic [4:0]  s3_rd;
    logic [31:0] s3_opr_a, s3_opr_b;
    logic [4:0]  s3_uop, s3_fu;
    logic        s3_trap, s3_valid, s3_busy;
    logic        dmem_req, dmem_gnt, dmem_wen;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_recv, dmem_error;
    logic [31:0] dmem_rdata;
    logic [4:0]  s4_rd;
    logic [31:0] s4_wdata;
    logic [4:0]  s4_fu;
    logic        s4_trap;
    logic [5:0]  s4_cause;
    logic        s4_valid, s4_busy;

    frv_pipeline_memory #(.XL(XL), .P_FU_LSU(P_FU_LSU), .LSU_LOAD(4), .LSU_STORE(3)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .s3_rd(s3_rd), .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b), .s3_uop(s3_uop),
        .s3_fu(s3_fu), .s3_trap(s3_trap), .s3_valid(s3_valid), .s3_busy(s3_busy),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_wen(dmem_wen),
        .dmem_strb(dmem_strb), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .s4_rd(s4_rd), .s4_wdata(s4_wdata), .s4_fu(s4_fu), .s4_trap(s4_trap),
        .s4_cause(s4_cause), .s4_valid(s4_valid), .s4_busy(s4_busy)
    );

    always #5 g_clk = ~g_clk;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  uop;
        logic [4:0]  fu;
        logic        trap;
        logic        flush;
        logic        busy;
        logic        gnt;
        logic        recv;
        logic        err;
        logic [31:0] rdata;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [4:0]  fu;
        logic        trap;
        logic [5:0]  cause;
    } s4_t;

    typedef struct packed {
        logic        valid;
        logic        granted;
        logic        killed;
        logic [4:0]  rd;
        logic [4:0]  fu;
        logic [4:0]  uop;
        logic [31:0] a;
        logic [31:0] b;
    } pend_t;

    s4_t   m_s4;
    pend_t m_pend;
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam logic [4:0] FU_ALU = 5'b00001;
    localparam logic [4:0] FU_LSU = 5'b00100;
    localparam logic [4:0] U_LW   = 5'b10100;
    localparam logic [4:0] U_LB   = 5'b10000;
    localparam logic [4:0] U_LBU  = 5'b10001;
    localparam logic [4:0] U_SH   = 5'b01010;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned nbytes(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic aligned(input logic [4:0] uop, input logic [31:0] a);
        if (uop[2:1] == 2'b11) return 1'b0;
        return (a % nbytes(uop[2:1])) == 0;
    endfunction

    function automatic logic [3:0] exp_strb(input logic [4:0] uop, input logic [31:0] a);
        int unsigned n;
        if (uop[4]) return 4'b0000;
        n = nbytes(uop[2:1]);
        return 4'(((32'd1 << n) - 32'd1) << a[1:0]);
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [4:0] uop, input logic [31:0] b);
        case (uop[2:1])
            2'd0:    return 32'(b[7:0]) * 32'h01010101;
            2'd1:    return 32'(b[15:0]) * 32'h00010001;
            default: return b;
        endcase
    endfunction

    function automatic s4_t pass_result(input stim_t s);
        s4_t r;
        r.valid = 1'b1;
        r.rd    = s.rd;
        r.fu    = s.fu;
        r.wdata = s.a;
        r.trap  = s.trap || s.fu[P_FU_LSU];
        if (s.trap)                r.cause = s.b[5:0];
        else if (s.fu[P_FU_LSU])   r.cause = s.uop[4] ? 6'd4 : 6'd6;
        else                       r.cause = 6'd0;
        return r;
    endfunction

    function automatic s4_t lsu_result(input pend_t p, input logic err, input logic [31:0] rdata);
        s4_t r;
        logic [31:0] v;
        int unsigned n;
        r.valid = 1'b1;
        r.rd    = p.rd;
        r.fu    = p.fu;
        if (err) begin
            r.trap  = 1'b1;
            r.cause = p.uop[4] ? 6'd5 : 6'd7;
            r.wdata = p.a;
        end else begin
            r.trap  = 1'b0;
            r.cause = 6'd0;
            r.wdata = 32'd0;
            if (p.uop[4]) begin
                n = nbytes(p.uop[2:1]);
                v = rdata >> (32'd8 * 32'(p.a[1:0]));
                if (n < 4) begin
                    v = v % (32'd1 << (8 * n));
                    if (!p.uop[0] && v >= (32'd1 << (8 * n - 1))) v = v - (32'd1 << (8 * n));
                end
                r.wdata = v;
            end
        end
        return r;
    endfunction

    function automatic stim_t idle_s();
        stim_t s = '0;
        return s;
    endfunction

    function automatic stim_t op_s(input logic [4:0] fu, input logic [4:0] uop,
                                   input logic [31:0] a, input logic [31:0] b);
        stim_t s = '0;
        s.valid = 1'b1;
        s.rd    = 5'd7;
        s.fu    = fu;
        s.uop   = uop;
        s.a     = a;
        s.b     = b;
        return s;
    endfunction

    task automatic drive(input stim_t s);
        s3_valid   = s.valid;
        s3_rd      = s.rd;
        s3_opr_a   = s.a;
        s3_opr_b   = s.b;
        s3_uop     = s.uop;
        s3_fu      = s.fu;
        s3_trap    = s.trap;
        flush      = s.flush;
        s4_busy    = s.busy;
        dmem_gnt   = s.gnt;
        dmem_recv  = s.recv;
        dmem_error = s.err;
        dmem_rdata = s.rdata;
    endtask

    // One clock: drive, compare against the model, advance the model
    task automatic cycle(input stim_t s);
        s4_t   n4;
        pend_t np;
        logic  busy_e, xfer, req_e;
        @(negedge g_clk);
        drive(s);
        #1;
        busy_e = m_pend.valid || (m_s4.valid && s.busy);
        req_e  = m_pend.valid && !m_pend.granted;
        chk("s3_busy", 32'(s3_busy), 32'(busy_e));
        chk("s4_valid", 32'(s4_valid), 32'(m_s4.valid));
        if (m_s4.valid) begin
            chk("s4_rd", 32'(s4_rd), 32'(m_s4.rd));
            chk("s4_fu", 32'(s4_fu), 32'(m_s4.fu));
            chk("s4_wdata", s4_wdata, m_s4.wdata);
            chk("s4_trap", 32'(s4_trap), 32'(m_s4.trap));
            chk("s4_cause", 32'(s4_cause), 32'(m_s4.cause));
        end
        chk("dmem_req", 32'(dmem_req), 32'(req_e));
        if (req_e) begin
            chk("dmem_addr", dmem_addr, {m_pend.a[31:2], 2'b00});
            chk("dmem_wen", 32'(dmem_wen), 32'(!m_pend.uop[4]));
            chk("dmem_strb", 32'(dmem_strb), 32'(exp_strb(m_pend.uop, m_pend.a)));
            if (!m_pend.uop[4]) chk("dmem_wdata", dmem_wdata, exp_wdata(m_pend.uop, m_pend.b));
        end

        n4 = m_s4;
        np = m_pend;
        if (m_s4.valid && !s.busy) n4.valid = 1'b0;
        if (m_pend.valid) begin
            if (!m_pend.granted) begin
                if (s.gnt) np.granted = 1'b1;
            end else if (s.recv) begin
                np.valid = 1'b0;
                if (!m_pend.killed) n4 = lsu_result(m_pend, s.err, s.rdata);
            end
            if (s.flush) np.killed = 1'b1;
        end
        xfer = s.valid && !busy_e && !s.flush;
        if (xfer) begin
            if (s.fu[P_FU_LSU] && !s.trap && aligned(s.uop, s.a)) begin
                np = '0;
                np.valid = 1'b1;
                np.rd = s.rd;
                np.fu = s.fu;
                np.uop = s.uop;
                np.a = s.a;
                np.b = s.b;
            end else begin
                n4 = pass_result(s);
            end
        end
        if (s.flush) n4.valid = 1'b0;
        @(posedge g_clk);
        m_s4   = n4;
        m_pend = np;
    endtask

    function automatic stim_t rand_s();
        stim_t s;
        int unsigned width, sel;
        logic ld;
        s.valid = ($urandom_range(0, 9) < 7);
        s.rd    = 5'($urandom);
        s.a     = $urandom;
        s.b     = $urandom;
        if ($urandom_range(0, 1) == 0) s.a[1:0] = 2'b00;
        if ($urandom_range(0, 1) == 0) begin
            s.fu = FU_LSU;
        end else begin
            sel  = $urandom_range(0, 3);
            s.fu = 5'(32'd1 << ((sel < 2) ? sel : sel + 1));
        end
        width = ($urandom_range(0, 15) == 0) ? 3 : $urandom_range(0, 2);
        ld    = 1'($urandom_range(0, 1));
        s.uop = {ld, ~ld, 2'(width), 1'($urandom_range(0, 1))};
        s.trap  = ($urandom_range(0, 19) == 0);
        s.flush = ($urandom_range(0, 24) == 0);
        s.busy  = ($urandom_range(0, 3) == 0);
        s.gnt   = m_pend.valid && !m_pend.granted && ($urandom_range(0, 2) != 0);
        s.recv  = m_pend.valid && m_pend.granted && ($urandom_range(0, 2) != 0);
        s.err   = ($urandom_range(0, 7) == 0);
        s.rdata = $urandom;
        return s;
    endfunction

    task automatic chk_reset_outputs();
        chk("rst_s3_busy", 32'(s3_busy), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_wen", 32'(dmem_wen), 32'd0);
        chk("rst_dmem_strb", 32'(dmem_strb), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_s4_valid", 32'(s4_valid), 32'd0);
        chk("rst_s4_trap", 32'(s4_trap), 32'd0);
        chk("rst_s4_cause", 32'(s4_cause), 32'd0);
        chk("rst_s4_wdata", s4_wdata, 32'd0);
        chk("rst_s4_rd", 32'(s4_rd), 32'd0);
        chk("rst_s4_fu", 32'(s4_fu), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        m_s4 = '0;
        m_pend = '0;
        drive(idle_s());
        g_reset = 1'b1;
        repeat (3) @(posedge g_clk);
        @(negedge g_clk);
        chk_reset_outputs();
        g_reset = 1'b0;

        // LW aligned, immediate grant
        cycle(op_s(FU_LSU, U_LW, 32'h1004, 32'h0));
        #2;
        chk("lw_req", 32'(dmem_req), 32'd1);
        chk("lw_addr", dmem_addr, 32'h1004);
        chk("lw_strb", 32'(dmem_strb), 32'd0);
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'hDEADBEEF; cycle(s);
        #2;
        chk("lw_valid", 32'(s4_valid), 32'd1);
        chk("lw_wdata", s4_wdata, 32'hDEADBEEF);
        chk("lw_trap", 32'(s4_trap), 32'd0);
        cycle(idle_s());

        // LB / LBU from byte offset 3
        cycle(op_s(FU_LSU, U_LB, 32'h1003, 32'h0));
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'h80112233; cycle(s);
        #2;
        chk("lb_wdata", s4_wdata, 32'hFFFFFF80);
        cycle(op_s(FU_LSU, U_LBU, 32'h1003, 32'h0));
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'h80112233; cycle(s);
        #2;
        chk("lbu_wdata", s4_wdata, 32'h00000080);
        cycle(idle_s());

        // SH upper half
        cycle(op_s(FU_LSU, U_SH, 32'h2002, 32'h1234ABCD));
        #2;
        chk("sh_strb", 32'(dmem_strb), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hABCDABCD);
        chk("sh_addr", dmem_addr, 32'h2000);
        chk("sh_wen", 32'(dmem_wen), 32'd1);
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'h55555555; cycle(s);
        #2;
        chk("sh_s4_wdata", s4_wdata, 32'd0);
        cycle(idle_s());

        // Misaligned LW
        cycle(op_s(FU_LSU, U_LW, 32'h1002, 32'h0));
        #2;
        chk("mis_req", 32'(dmem_req), 32'd0);
        chk("mis_trap", 32'(s4_trap), 32'd1);
        chk("mis_cause", 32'(s4_cause), 32'd4);
        cycle(idle_s());

        // Flush while waiting for the response
        cycle(op_s(FU_LSU, U_LW, 32'h3000, 32'h0));
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        s = idle_s(); s.flush = 1'b1; cycle(s);
        #2;
        chk("fl_busy", 32'(s3_busy), 32'd1);
        chk("fl_valid", 32'(s4_valid), 32'd0);
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'h12345678; cycle(s);
        #2;
        chk("fl_valid2", 32'(s4_valid), 32'd0);
        chk("fl_busy2", 32'(s3_busy), 32'd0);

        // Downstream stall holds an ALU result
        cycle(op_s(FU_ALU, 5'd0, 32'h55, 32'h0));
        for (int i = 0; i < 3; i++) begin
            s = op_s(FU_ALU, 5'd0, 32'h66, 32'h0); s.busy = 1'b1; cycle(s);
            #2;
            chk("stall_wdata", s4_wdata, 32'h55);
            chk("stall_busy", 32'(s3_busy), 32'd1);
        end
        cycle(op_s(FU_ALU, 5'd0, 32'h66, 32'h0));
        #2;
        chk("rel_wdata", s4_wdata, 32'h66);
        chk("rel_valid", 32'(s4_valid), 32'd1);
        cycle(idle_s());

        // Reset abandons an in-flight access; a late response is ignored
        cycle(op_s(FU_LSU, U_LW, 32'h4000, 32'h0));
        s = idle_s(); s.gnt = 1'b1; cycle(s);
        @(negedge g_clk);
        drive(idle_s());
        g_reset = 1'b1;
        #1;
        chk_reset_outputs();
        m_s4 = '0;
        m_pend = '0;
        @(negedge g_clk);
        g_reset = 1'b0;
        s = idle_s(); s.recv = 1'b1; s.rdata = 32'hCAFEF00D; cycle(s);
        #2;
        chk("late_recv_valid", 32'(s4_valid), 32'd0);
        cycle(idle_s());

        for (int i = 0; i < 4000; i++) cycle(rand_s());
        repeat (20) begin
            s = idle_s();
            s.gnt  = m_pend.valid && !m_pend.granted;
            s.recv = m_pend.valid && m_pend.granted;
            cycle(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
